// File: rtl/burst_line_master.sv
// -----------------------------------------------------------------------------
// burst_line_master
//
// Burst-RAM command initiator. A client hands over one cache line per
// request (read or write). The master issues a single burst command and
// then either streams the BURST_COUNT words of the line out on
// mem_wr_data, one word per cycle, or collects BURST_COUNT read beats
// into a staging buffer. The finished line is presented on rd_line
// together with a one-cycle done pulse. A read whose beats do not all
// arrive within TIMEOUT_CYCLES of command issue is abandoned with a
// one-cycle timeout_err pulse. In that case rd_line keeps its old value.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready client request handshake (req_ready combinational)
//   req_write           1: write line, 0: read line
//   req_addr            first word address of the line
//   req_wr_line         write line, word k at [k*DATA_BITWIDTH +: DATA_BITWIDTH]
//   rd_line             last completed read line, same packing
//   done                one-cycle pulse at transfer completion
//   timeout_err         one-cycle pulse when a read is abandoned
//   mem_cmd/mem_cmd_en  burst command (0 read, 1 write) and its strobe
//   mem_addr            burst start address (unaligned, the memory wraps)
//   mem_wr_data         write beat data
//   mem_data_mask       byte mask, always 0 (full-word writes only)
//   mem_rd_data(_valid) read beat data and qualifier
//   mem_busy            memory calibrating or executing a burst
// -----------------------------------------------------------------------------
module burst_line_master #(
  parameter int ADDR_BITWIDTH  = 4,
  parameter int DATA_BITWIDTH  = 64,
  parameter int BURST_COUNT    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  input  logic                                 req_write,
  input  logic [ADDR_BITWIDTH-1:0]             req_addr,
  input  logic [DATA_BITWIDTH*BURST_COUNT-1:0] req_wr_line,
  output logic                                 req_ready,
  output logic [DATA_BITWIDTH*BURST_COUNT-1:0] rd_line,
  output logic                                 done,
  output logic                                 timeout_err,
  output logic                                 mem_cmd,
  output logic                                 mem_cmd_en,
  output logic [ADDR_BITWIDTH-1:0]             mem_addr,
  output logic [DATA_BITWIDTH-1:0]             mem_wr_data,
  output logic [DATA_BITWIDTH/8-1:0]           mem_data_mask,
  input  logic [DATA_BITWIDTH-1:0]             mem_rd_data,
  input  logic                                 mem_rd_data_valid,
  input  logic                                 mem_busy
);

  localparam int LINE_W = DATA_BITWIDTH * BURST_COUNT;
  localparam int BEAT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_COUNT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

  // Elaboration-time parameter sanity checks.
  if ((DATA_BITWIDTH % 8) != 0) begin : g_chk_dw
    $error("DATA_BITWIDTH must be a multiple of 8");
  end
  if ((BURST_COUNT < 2) || ((BURST_COUNT & (BURST_COUNT - 1)) != 0)) begin : g_chk_bc
    $error("BURST_COUNT must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_tmo
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WRITE_BURST = 2'd1,
    READ_WAIT   = 2'd2
  } state_t;

  // Word k of a packed line.
  function automatic logic [DATA_BITWIDTH-1:0] get_word(input logic [LINE_W-1:0] line,
                                                        input int                idx);
    return line[idx*DATA_BITWIDTH +: DATA_BITWIDTH];
  endfunction

  state_t                     state_q, state_d;
  logic [BEAT_W-1:0]          beat_q, beat_d;
  logic [TMO_W-1:0]           tmo_q, tmo_d;
  logic                       mem_cmd_en_q, mem_cmd_en_d;
  logic                       mem_cmd_q, mem_cmd_d;
  logic [ADDR_BITWIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_BITWIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;
  logic [LINE_W-1:0]          rd_line_q, rd_line_d;
  logic                       done_q, done_d;
  logic                       tmo_err_q, tmo_err_d;
  logic [LINE_W-1:0]          wr_line_q, wr_line_d;
  logic [LINE_W-1:0]          rd_buf_q, rd_buf_d;
  logic                       accept;

  // The only combinational output. Gating with rst keeps the client from
  // seeing a handshake during the reset cycle itself.
  assign req_ready = (state_q == IDLE) && !mem_busy && !rst;
  assign accept    = req_valid && req_ready;

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    tmo_d         = tmo_q;
    mem_cmd_en_d  = 1'b0;
    mem_cmd_d     = mem_cmd_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rd_line_d     = rd_line_q;
    done_d        = 1'b0;
    tmo_err_d     = 1'b0;
    wr_line_d     = wr_line_q;
    rd_buf_d      = rd_buf_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_line_d    = req_wr_line;
          mem_cmd_en_d = 1'b1;
          mem_cmd_d    = req_write;
          mem_addr_d   = req_addr;
          beat_d       = '0;
          tmo_d        = '0;
          if (req_write) begin
            // Word 0 goes out together with the command strobe.
            mem_wr_data_d = get_word(req_wr_line, 0);
            state_d       = WRITE_BURST;
          end else begin
            state_d       = READ_WAIT;
          end
        end
      end

      WRITE_BURST: begin
        // beat_q names the word currently on mem_wr_data.
        if (beat_q == LAST_BEAT) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          beat_d        = beat_q + BEAT_W'(1);
          mem_wr_data_d = get_word(wr_line_q, int'(beat_q) + 1);
        end
      end

      READ_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (mem_rd_data_valid) begin
          rd_buf_d[int'(beat_q)*DATA_BITWIDTH +: DATA_BITWIDTH] = mem_rd_data;
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == LAST_BEAT) begin
            // Publish the whole line at once so rd_line never shows a
            // partially filled burst.
            rd_line_d = rd_buf_d;
            done_d    = 1'b1;
            state_d   = IDLE;
          end
        end
        // A last beat arriving in the final allowed cycle still completes.
        if ((state_d == READ_WAIT) && (tmo_q == TMO_LAST)) begin
          tmo_err_d = 1'b1;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and client-visible registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      tmo_q         <= '0;
      mem_cmd_en_q  <= 1'b0;
      mem_cmd_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rd_line_q     <= '0;
      done_q        <= 1'b0;
      tmo_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      tmo_q         <= tmo_d;
      mem_cmd_en_q  <= mem_cmd_en_d;
      mem_cmd_q     <= mem_cmd_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rd_line_q     <= rd_line_d;
      done_q        <= done_d;
      tmo_err_q     <= tmo_err_d;
    end
  end

  // Line staging registers; their contents only matter once qualified by state
  always_ff @(posedge clk) begin
    wr_line_q <= wr_line_d;
    rd_buf_q  <= rd_buf_d;
  end

  assign mem_cmd_en    = mem_cmd_en_q;
  assign mem_cmd       = mem_cmd_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wr_data   = mem_wr_data_q;
  assign mem_data_mask = '0;
  assign rd_line       = rd_line_q;
  assign done          = done_q;
  assign timeout_err   = tmo_err_q;

endmodule

// File: tb/tb_burst_line_master.sv
// -----------------------------------------------------------------------------
// tb_burst_line_master
//
// Directed and randomized bench for burst_line_master with a small burst RAM
// emulator (configurable read delay, beat gap and a silent mode) and a
// line-level reference memory model.
// -----------------------------------------------------------------------------
module tb_burst_line_master;

  localparam int AW = 4;
  localparam int DW = 64;
  localparam int BC = 4;
  localparam int LW = DW * BC;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid;
  logic            req_write;
  logic [AW-1:0]   req_addr;
  logic [LW-1:0]   req_wr_line;
  logic            req_ready;
  logic [LW-1:0]   rd_line;
  logic            done;
  logic            timeout_err;
  logic            mem_cmd;
  logic            mem_cmd_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wr_data;
  logic [DW/8-1:0] mem_data_mask;
  logic [DW-1:0]   mem_rd_data = '0;
  logic            mem_rd_data_valid = 1'b0;
  logic            mem_busy = 1'b1;

  burst_line_master #(
    .ADDR_BITWIDTH (AW),
    .DATA_BITWIDTH (DW),
    .BURST_COUNT   (BC),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_wr_line      (req_wr_line),
    .req_ready        (req_ready),
    .rd_line          (rd_line),
    .done             (done),
    .timeout_err      (timeout_err),
    .mem_cmd          (mem_cmd),
    .mem_cmd_en       (mem_cmd_en),
    .mem_addr         (mem_addr),
    .mem_wr_data      (mem_wr_data),
    .mem_data_mask    (mem_data_mask),
    .mem_rd_data      (mem_rd_data),
    .mem_rd_data_valid(mem_rd_data_valid),
    .mem_busy         (mem_busy)
  );

  always #5 clk = ~clk;

  // ---------------- burst RAM emulator ----------------
  logic [DW-1:0] pre_mem [16];
  logic [DW-1:0] emu_mem [16];
  int            delay_cfg  = 8;
  int            gap_cfg    = 0;
  bit            silent_cfg = 1'b0;
  int unsigned   cyc = 0;
  int            cal_cnt = 0;
  logic          rd_act = 1'b0;
  logic [2:0]    rd_bi = '0;
  int unsigned   rd_next = 0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_act = 1'b0;
  logic [2:0]    wr_k = '0;
  logic [AW-1:0] wr_addr = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      for (int i = 0; i < 16; i++) emu_mem[i] <= pre_mem[i];
      mem_busy          <= 1'b1;
      cal_cnt           <= 12;
      rd_act            <= 1'b0;
      wr_act            <= 1'b0;
      mem_rd_data_valid <= 1'b0;
      mem_rd_data       <= '0;
    end else begin
      mem_rd_data_valid <= 1'b0;
      if (cal_cnt > 0) begin
        cal_cnt <= cal_cnt - 1;
        if (cal_cnt == 1) mem_busy <= 1'b0;
      end
      if (mem_cmd_en) begin
        if (mem_cmd) begin
          emu_mem[mem_addr] <= mem_wr_data;
          wr_act   <= 1'b1;
          wr_k     <= 3'd1;
          wr_addr  <= mem_addr;
          mem_busy <= 1'b1;
        end else if (!silent_cfg) begin
          rd_act   <= 1'b1;
          rd_bi    <= 3'd0;
          rd_next  <= cyc + delay_cfg - 1;
          rd_addr  <= mem_addr;
          mem_busy <= 1'b1;
        end
      end
      if (wr_act) begin
        emu_mem[wr_addr + 4'(wr_k)] <= mem_wr_data;
        wr_k <= wr_k + 3'd1;
        if (wr_k == 3'd3) begin
          wr_act   <= 1'b0;
          mem_busy <= 1'b0;
        end
      end
      if (rd_act) begin
        if (rd_bi == 3'd4) begin
          rd_act   <= 1'b0;
          mem_busy <= 1'b0;
        end else if (cyc == rd_next) begin
          mem_rd_data_valid <= 1'b1;
          mem_rd_data       <= emu_mem[rd_addr + 4'(rd_bi)];
          rd_bi             <= rd_bi + 3'd1;
          rd_next           <= rd_next + 1 + ((rd_bi == 3'd1) ? gap_cfg : 0);
        end
      end
    end
  end

  // ---------------- reference model and checking ----------------
  logic [DW-1:0] ref_mem [16];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < BC; k++) l[k*DW +: DW] = ref_mem[(int'(a) + k) % 16];
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int k = 0; k < BC; k++) l[k*DW +: DW] = {$urandom, $urandom};
    return l;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_ready"}, req_ready, 1'b1);
  endtask

  // Hands a request over; returns in the cycle the command strobe is visible.
  task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] line,
                       input string tag);
    wait_ready(tag);
    req_valid   = 1'b1;
    req_write   = wr;
    req_addr    = a;
    req_wr_line = line;
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_cmd"}, {mem_cmd_en, mem_cmd, mem_addr}, {1'b1, wr, a});
  endtask

  task automatic finish_write(input logic [AW-1:0] a, input logic [LW-1:0] line,
                              input string tag);
    bit ok = 1'b1;
    for (int k = 0; k < BC; k++) begin
      if (k > 0) @(negedge clk);
      chk({tag, "_wdata"}, mem_wr_data, line[k*DW +: DW]);
      if (done !== 1'b0) ok = 1'b0;
      if (k > 0 && mem_cmd_en !== 1'b0) ok = 1'b0;
    end
    chk({tag, "_no_early_done"}, ok, 1'b1);
    @(negedge clk);
    chk({tag, "_done"}, done, 1'b1);
    for (int k = 0; k < BC; k++) ref_mem[(int'(a) + k) % 16] = line[k*DW +: DW];
  endtask

  task automatic finish_read(input logic [AW-1:0] a, input int dly, input int gp,
                             input string tag);
    int c = 1;
    int last = -1;
    @(negedge clk);
    chk({tag, "_cmd_once"}, mem_cmd_en, 1'b0);
    while (done !== 1'b1 && c < 200) begin
      if (mem_rd_data_valid === 1'b1) last = c;
      @(negedge clk);
      c++;
    end
    chk({tag, "_latency"}, c, dly + BC + gp);
    chk({tag, "_after_last_beat"}, last + 1, c);
    chk({tag, "_line"}, rd_line, ref_line(a));
    @(negedge clk);
    chk({tag, "_pulse"}, done, 1'b0);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [LW-1:0] line, input string tag);
    issue(1'b1, a, line, tag);
    finish_write(a, line, tag);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int dly, input int gp, input string tag);
    delay_cfg = dly;
    gap_cfg   = gp;
    issue(1'b0, a, '0, tag);
    finish_read(a, dly, gp, tag);
    gap_cfg = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed hang required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [LW-1:0] l1, wl, line2, saved;
    logic [AW-1:0] a;
    bit            ok;
    int            ncmd, ndone, c2, d1, d2, c;
    logic          busy_at;

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wr_line = '0;
    for (int i = 0; i < 16; i++) begin
      pre_mem[i] = {$urandom, $urandom};
      ref_mem[i] = pre_mem[i];
    end
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_cmd_en", mem_cmd_en, 1'b0);
    chk("rst_cmd", mem_cmd, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_wdata", mem_wr_data, '0);
    chk("rst_rd_line", rd_line, '0);
    chk("rst_pulses", {done, timeout_err}, 2'b00);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_mask", mem_data_mask, '0);

    // Calibration with a request pending: the write at addr 4
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = 4'd4;
    req_wr_line = l1;
    rst         = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || mem_cmd_en !== 1'b0 || mem_busy !== 1'b1) ok = 1'b0;
    end
    chk("cal_hold", ok, 1'b1);
    @(negedge clk);
    chk("cal_ready", {mem_busy, req_ready, mem_cmd_en}, 3'b010);
    @(negedge clk);
    req_valid = 1'b0;
    chk("cal_cmd", {mem_cmd_en, mem_cmd, mem_addr}, {1'b1, 1'b1, 4'd4});
    finish_write(4'd4, l1, "wr4");

    // Read the line back with read delay 8
    do_read(4'd4, 8, 0, "rd4");
    chk("rd4_exact", rd_line, l1);

    // Back-to-back: write addr 0 then read addr 8 with req_valid held
    wait_ready("b2b");
    wl          = rand_line();
    delay_cfg   = 8;
    req_valid   = 1'b1;
    req_write   = 1'b1;
    req_addr    = 4'd0;
    req_wr_line = wl;
    @(negedge clk);
    chk("b2b_cmd1", {mem_cmd_en, mem_cmd}, 2'b11);
    req_write = 1'b0;
    req_addr  = 4'd8;
    ncmd = 1; ndone = 0; c2 = -1; d1 = -1; d2 = -1; busy_at = 1'b1; line2 = '0;
    for (int i = 1; i < 30; i++) begin
      @(negedge clk);
      if (mem_cmd_en === 1'b1) begin
        ncmd++;
        if (c2 < 0) begin
          c2 = i;
          req_valid = 1'b0;
        end
      end
      if (done === 1'b1) begin
        ndone++;
        if (d1 < 0) d1 = i;
        else begin
          d2 = i;
          line2 = rd_line;
        end
      end
      if (i == 4) busy_at = mem_busy;
    end
    req_valid = 1'b0;
    for (int k = 0; k < BC; k++) ref_mem[k] = wl[k*DW +: DW];
    chk("b2b_ncmd", ncmd, 2);
    chk("b2b_cmd2_cycle", c2, 5);
    chk("b2b_wr_done", d1, 4);
    chk("b2b_busy_low", busy_at, 1'b0);
    chk("b2b_rd_done", d2, 17);
    chk("b2b_ndone", ndone, 2);
    chk("b2b_rd_line", line2, ref_line(4'd8));
    do_read(4'd0, 3, 0, "b2b_wrchk");

    // Wrap around the top of the address space
    do_read(4'd14, 5, 0, "wrap");

    // Gap of three idle cycles between beats 1 and 2
    do_read(4'd4, 8, 3, "gap");

    // Randomized write/read traffic
    for (int it = 0; it < 6; it++) begin
      a = 4'($urandom_range(0, 15));
      do_write(a, rand_line(), "rnd_wr");
      if ($urandom_range(0, 1) == 1) a = 4'($urandom_range(0, 15));
      do_read(a, $urandom_range(2, 10), $urandom_range(0, 3), "rnd_rd");
    end

    // Timeout: the memory never returns data
    saved      = rd_line;
    silent_cfg = 1'b1;
    issue(1'b0, 4'd6, '0, "tmo");
    c = 0;
    ndone = 0;
    while (timeout_err !== 1'b1 && c < 200) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
      c++;
    end
    chk("tmo_cycle", c, 64);
    chk("tmo_no_done", {ndone[0], done}, 2'b00);
    chk("tmo_rd_line", rd_line, saved);
    @(negedge clk);
    chk("tmo_pulse", timeout_err, 1'b0);
    chk("tmo_ready", req_ready, 1'b1);
    silent_cfg = 1'b0;

    // Reset in the middle of a read
    delay_cfg = 8;
    issue(1'b0, 4'd2, '0, "mid");
    c = 0;
    ndone = 0;
    while (ndone < 3 && c < 100) begin
      @(negedge clk);
      c++;
      if (mem_rd_data_valid === 1'b1) ndone++;
    end
    chk("mid_beats_seen", ndone, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctrl", {mem_cmd_en, mem_cmd, done, timeout_err, req_ready}, 5'b00000);
    chk("mid_rst_addr", mem_addr, '0);
    chk("mid_rst_wdata", mem_wr_data, '0);
    chk("mid_rst_rd_line", rd_line, '0);
    ok = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0 || timeout_err !== 1'b0) ok = 1'b0;
    end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) ref_mem[i] = pre_mem[i];
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || timeout_err !== 1'b0) ok = 1'b0;
    end
    chk("mid_no_pulse", ok, 1'b1);
    do_read(4'd8, 4, 1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
